// File: rtl/cmsdk_apb_to_ahb_sync_if.sv
// APB4 completer and AHB-Lite manager signals of the bridge, bundled.
// The master modport is the bridge's own view; slave is the system/bench view.
interface cmsdk_apb_to_ahb_sync_if #(
  parameter int ADDRWIDTH = 16
);
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [31:0]          PWDATA;
  logic [3:0]           PSTRB;
  logic [2:0]           PPROT;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;
  logic [31:0]          HADDR;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic                 HMASTLOCK;
  logic [3:0]           HPROT;
  logic                 HWRITE;
  logic [31:0]          HWDATA;
  logic [31:0]          HRDATA;
  logic                 HREADY;
  logic                 HRESP;

  modport master (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR,
    output HADDR, HTRANS, HSIZE, HBURST, HMASTLOCK, HPROT, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR,
    input  HADDR, HTRANS, HSIZE, HBURST, HMASTLOCK, HPROT, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/cmsdk_apb_to_ahb_sync.sv
// Synchronous APB4 completer to AHB-Lite manager bridge: each APB transfer is
// replayed as one AHB single transfer; read data and error return on APB.
module cmsdk_apb_to_ahb_sync #(
  parameter int          ADDRWIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  cmsdk_apb_to_ahb_sync_if.master bus,
  output logic       BUSY,
  output logic [1:0] state_dbg
);

  // Handshake: APB setup is PSEL & ~PENABLE; the access phase holds until the
  // registered PREADY pulses for one cycle. On AHB, NONSEQ is held until
  // HREADY=1, and the data phase ends on the next HREADY=1 cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0] haddr_q;
  logic [2:0]  hsize_q;
  logic        hwrite_q;
  logic [3:0]  hprot_q;
  logic [31:0] hwdata_q;
  logic        abort_q;
  logic        pready_q;
  logic        pslverr_q;
  logic [31:0] prdata_q;

  logic        setup;
  logic [2:0]  dec_size;
  logic [1:0]  dec_lane;
  logic        dec_null;
  logic        dec_bad;
  logic        resp_load;
  logic        resp_err;
  logic [31:0] resp_data;

  assign setup = bus.PSEL & ~bus.PENABLE;

  // Write strobes select transfer size and byte lane; reads are always words.
  always_comb begin
    dec_size = 3'b010;
    dec_lane = 2'b00;
    dec_null = 1'b0;
    dec_bad  = 1'b0;
    if (bus.PWRITE) begin
      case (bus.PSTRB)
        4'b1111: dec_size = 3'b010;
        4'b0011: dec_size = 3'b001;
        4'b1100: begin dec_size = 3'b001; dec_lane = 2'b10; end
        4'b0001: begin dec_size = 3'b000; dec_lane = 2'b00; end
        4'b0010: begin dec_size = 3'b000; dec_lane = 2'b01; end
        4'b0100: begin dec_size = 3'b000; dec_lane = 2'b10; end
        4'b1000: begin dec_size = 3'b000; dec_lane = 2'b11; end
        4'b0000: dec_null = 1'b1;
        default: dec_bad  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    resp_load = 1'b0;
    resp_err  = 1'b0;
    resp_data = 32'h0;
    case (state)
      IDLE: begin
        if (setup) begin
          if (dec_null || dec_bad) begin
            state_nxt = RESP;
            resp_load = 1'b1;
            resp_err  = dec_bad;
          end else begin
            state_nxt = ADDR;
          end
        end
      end
      ADDR: if (bus.HREADY) state_nxt = DATA;
      DATA: begin
        if (bus.HREADY) begin
          // A requester that dropped PSEL gets no response at all.
          if (abort_q || !bus.PSEL) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
            resp_load = 1'b1;
            resp_err  = bus.HRESP;
            resp_data = (!hwrite_q && !bus.HRESP) ? bus.HRDATA : 32'h0;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q   <= 32'h0;
      hsize_q   <= 3'b010;
      hwrite_q  <= 1'b0;
      hprot_q   <= 4'b0001;
      hwdata_q  <= 32'h0;
      abort_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'h0;
    end else begin
      if (state == IDLE && setup) begin
        haddr_q  <= {BASE_ADDR[31:ADDRWIDTH], bus.PADDR[ADDRWIDTH-1:2], dec_lane};
        hsize_q  <= dec_size;
        hwrite_q <= bus.PWRITE;
        hprot_q  <= {2'b00, bus.PPROT[0], ~bus.PPROT[2]};
        hwdata_q <= bus.PWDATA;
      end
      abort_q   <= (state == ADDR || state == DATA) ? (abort_q | ~bus.PSEL) : 1'b0;
      pready_q  <= resp_load;
      pslverr_q <= resp_load & resp_err;
      prdata_q  <= resp_load ? resp_data : 32'h0;
    end
  end

  assign bus.HTRANS    = (state == ADDR) ? 2'b10 : 2'b00;
  assign bus.HADDR     = haddr_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HPROT     = hprot_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.HBURST    = 3'b000;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.PREADY    = pready_q;
  assign bus.PSLVERR   = pslverr_q;
  assign bus.PRDATA    = prdata_q;

  assign BUSY      = (state != IDLE);
  assign state_dbg = state;

  logic unused_bits;
  assign unused_bits = ^{bus.PPROT[1], bus.PADDR[1:0]};

endmodule

// File: tb/tb_cmsdk_apb_to_ahb_sync.sv
// Bench for cmsdk_apb_to_ahb_sync: vector table, random word transfers,
// and hand sequences for reset-in-flight and PSEL abort.
module tb_cmsdk_apb_to_ahb_sync;

  logic       HCLK;
  logic       HRESETn;
  logic       BUSY;
  logic [1:0] state_dbg;

  cmsdk_apb_to_ahb_sync_if #(.ADDRWIDTH(16)) bus ();

  cmsdk_apb_to_ahb_sync #(.ADDRWIDTH(16), .BASE_ADDR(32'h4000_0000)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .BUSY      (BUSY),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end, required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  // {haddr, hsize, hwrite, hprot, hwdata}
  logic [71:0] ahb_exp_q[$];
  // {pslverr, prdata}
  logic [32:0] resp_exp_q[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    int          aw;
    int          dw;
    logic        err;
    logic [31:0] hrdata;
    logic        exp_ns;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_size;
    logic [3:0]  exp_hprot;
    logic        exp_slverr;
    logic [31:0] exp_prdata;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [15:0] paddr, logic [31:0] pwdata,
                              logic [3:0] pstrb, logic [2:0] pprot, int aw, int dw,
                              logic err, logic [31:0] hrdata, logic ens,
                              logic [31:0] ehaddr, logic [2:0] esize, logic [3:0] ehprot,
                              logic eslv, logic [31:0] eprd, int elat);
    vec_t v;
    v.wr = wr; v.paddr = paddr; v.pwdata = pwdata; v.pstrb = pstrb; v.pprot = pprot;
    v.aw = aw; v.dw = dw; v.err = err; v.hrdata = hrdata;
    v.exp_ns = ens; v.exp_haddr = ehaddr; v.exp_size = esize; v.exp_hprot = ehprot;
    v.exp_slverr = eslv; v.exp_prdata = eprd; v.exp_lat = elat;
    return v;
  endfunction

  // ---------------- AHB slave model ----------------
  int          s_aw, s_dw;
  logic        s_err;
  logic [31:0] s_rdata;
  logic [31:0] s_exp_hwdata;
  logic        s_exp_wr;
  bit          in_data;
  bit          err_stage;
  int          nonseq_cnt;

  // Called #1 after each rising edge; drives HREADY/HRESP/HRDATA for this cycle.
  task automatic ahb_step();
    logic [71:0] e;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    if (in_data) begin
      if (s_dw > 0) begin
        bus.HREADY = 1'b0;
        s_dw--;
      end else if (s_err && !err_stage) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        err_stage  = 1'b1;
      end else begin
        bus.HRESP  = s_err;
        bus.HRDATA = s_rdata;
        in_data    = 1'b0;
        check("htrans_in_data", bus.HTRANS, 2'b00);
        if (s_exp_wr) check("hwdata", bus.HWDATA, s_exp_hwdata);
      end
    end else if (bus.HTRANS == 2'b10) begin
      if (s_aw > 0) begin
        bus.HREADY = 1'b0;
        s_aw--;
      end else begin
        nonseq_cnt++;
        in_data = 1'b1;
        if (ahb_exp_q.size() == 0) begin
          check("unexpected_nonseq", 1'b1, 1'b0);
        end else begin
          e = ahb_exp_q.pop_front();
          check("haddr", bus.HADDR, e[71:40]);
          check("hsize", bus.HSIZE, e[39:37]);
          check("hwrite", bus.HWRITE, e[36]);
          check("hprot", bus.HPROT, e[35:32]);
          check("hburst", bus.HBURST, 3'b000);
          s_exp_wr     = e[36];
          s_exp_hwdata = e[31:0];
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic apb_setup(input vec_t v);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = v.wr;
    bus.PADDR   = v.paddr;
    bus.PWDATA  = v.pwdata;
    bus.PSTRB   = v.pstrb;
    bus.PPROT   = v.pprot;
    bus.HREADY  = 1'b1;
    bus.HRESP   = 1'b0;
    s_aw = v.aw; s_dw = v.dw; s_err = v.err; s_rdata = v.hrdata;
    in_data = 1'b0; err_stage = 1'b0; nonseq_cnt = 0;
    if (v.exp_ns) ahb_exp_q.push_back({v.exp_haddr, v.exp_size, v.wr, v.exp_hprot, v.pwdata});
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    bit done;
    logic [32:0] e;
    @(posedge HCLK); #1;
    apb_setup(v);
    resp_exp_q.push_back({v.exp_slverr, v.exp_prdata});
    k = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge HCLK); #1;
      k++;
      bus.PENABLE = 1'b1;
      if (bus.PREADY) begin
        e = resp_exp_q.pop_front();
        check("pslverr", bus.PSLVERR, e[32]);
        check("prdata", bus.PRDATA, e[31:0]);
        check("latency", k, v.exp_lat);
        check("nonseq_count", nonseq_cnt, v.exp_ns);
        done = 1'b1;
      end else if (k > 60) begin
        check("pready_timeout", 1'b0, 1'b1);
        void'(resp_exp_q.pop_front());
        done = 1'b1;
      end else begin
        ahb_step();
      end
    end
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    check("busy_after_resp", BUSY, 1'b0);
    check("pready_pulse_len", bus.PREADY, 1'b0);
  endtask

  // ---------------- NONSEQ gap monitor ----------------
  bit prev_ns, seen_ns;
  int idle_run;
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (bus.HTRANS == 2'b10 && !prev_ns) begin
        if (seen_ns) check("htrans_idle_gap", idle_run >= 2, 1'b1);
        seen_ns  = 1'b1;
        idle_run = 0;
      end else if (bus.HTRANS == 2'b00) begin
        idle_run++;
      end
      prev_ns = (bus.HTRANS == 2'b10);
    end
  end

  // ---------------- test ----------------
  vec_t tab[14];
  vec_t rv;

  initial begin
    HRESETn = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 16'h0;
    bus.PWDATA = 32'h0; bus.PSTRB = 4'h0; bus.PPROT = 3'b000;
    bus.HRDATA = 32'h0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    prev_ns = 1'b0; seen_ns = 1'b0; idle_run = 0;

    //          wr paddr     pwdata        strb     prot   aw dw er hrdata         ns haddr          size    hprot    se prdata        lat
    tab[0]  = mk(1, 16'h0010, 32'hDEADBEEF, 4'b1111, 3'b000, 0, 0, 0, 32'h0,        1, 32'h4000_0010, 3'b010, 4'b0001, 0, 32'h0,        3);
    tab[1]  = mk(0, 16'h0040, 32'h0,        4'b0000, 3'b001, 0, 3, 0, 32'h1234_5678, 1, 32'h4000_0040, 3'b010, 4'b0011, 0, 32'h1234_5678, 6);
    tab[2]  = mk(1, 16'h0020, 32'h00AB_0000, 4'b0100, 3'b100, 0, 0, 0, 32'h0,        1, 32'h4000_0022, 3'b000, 4'b0000, 0, 32'h0,        3);
    tab[3]  = mk(1, 16'h0030, 32'hCAFE_0000, 4'b1100, 3'b000, 0, 1, 0, 32'h0,        1, 32'h4000_0032, 3'b001, 4'b0001, 0, 32'h0,        4);
    tab[4]  = mk(1, 16'h0044, 32'h1111_1111, 4'b0110, 3'b000, 0, 0, 0, 32'h0,        0, 32'h0,         3'b010, 4'b0001, 1, 32'h0,        1);
    tab[5]  = mk(1, 16'h0048, 32'h2222_2222, 4'b0000, 3'b000, 0, 0, 0, 32'h0,        0, 32'h0,         3'b010, 4'b0001, 0, 32'h0,        1);
    tab[6]  = mk(0, 16'h0050, 32'h0,        4'b0000, 3'b000, 0, 0, 1, 32'hBAD0_BAD0, 1, 32'h4000_0050, 3'b010, 4'b0001, 1, 32'h0,        4);
    tab[7]  = mk(0, 16'hFFFC, 32'h0,        4'b0000, 3'b101, 2, 0, 0, 32'hA5A5_5A5A, 1, 32'h4000_FFFC, 3'b010, 4'b0010, 0, 32'hA5A5_5A5A, 5);
    tab[8]  = mk(1, 16'h0007, 32'h7700_0000, 4'b1000, 3'b000, 0, 0, 0, 32'h0,        1, 32'h4000_0007, 3'b000, 4'b0001, 0, 32'h0,        3);
    tab[9]  = mk(0, 16'h0102, 32'h0,        4'b0110, 3'b000, 0, 0, 0, 32'h0F0F_0F0F, 1, 32'h4000_0100, 3'b010, 4'b0001, 0, 32'h0F0F_0F0F, 3);
    tab[10] = mk(1, 16'h0200, 32'h5555_AAAA, 4'b1111, 3'b000, 0, 1, 1, 32'h0,        1, 32'h4000_0200, 3'b010, 4'b0001, 1, 32'h0,        5);
    tab[11] = mk(1, 16'h1234, 32'h0000_9900, 4'b0010, 3'b011, 1, 0, 0, 32'h0,        1, 32'h4000_1235, 3'b000, 4'b0011, 0, 32'h0,        4);
    tab[12] = mk(1, 16'h0404, 32'h0000_BEEF, 4'b0011, 3'b000, 0, 0, 0, 32'h0,        1, 32'h4000_0404, 3'b001, 4'b0001, 0, 32'h0,        3);
    tab[13] = mk(1, 16'h0408, 32'h3333_3333, 4'b0101, 3'b000, 0, 0, 0, 32'h0,        0, 32'h0,         3'b010, 4'b0001, 1, 32'h0,        1);

    // Reset values
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_htrans", bus.HTRANS, 2'b00);
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_hsize", bus.HSIZE, 3'b010);
    check("rst_hwrite", bus.HWRITE, 1'b0);
    check("rst_hwdata", bus.HWDATA, 32'h0);
    check("rst_hprot", bus.HPROT, 4'b0001);
    check("rst_hmastlock", bus.HMASTLOCK, 1'b0);
    check("rst_pready", bus.PREADY, 1'b0);
    check("rst_prdata", bus.PRDATA, 32'h0);
    check("rst_pslverr", bus.PSLVERR, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    HRESETn = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tab[i]);

    // Random aligned word transfers with random wait states
    for (int i = 0; i < 8; i++) begin
      logic        wr;
      logic [15:0] pa;
      logic [31:0] d;
      logic [2:0]  pp;
      int          aw, dw;
      wr = 1'($urandom_range(0, 1));
      pa = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC;
      d  = $urandom;
      pp = 3'($urandom_range(0, 7));
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      rv = mk(wr, pa, wr ? d : 32'h0, wr ? 4'b1111 : 4'b0000, pp, aw, dw, 1'b0,
              wr ? 32'h0 : d, 1'b1, {16'h4000, pa}, 3'b010, {2'b00, pp[0], ~pp[2]},
              1'b0, wr ? 32'h0 : d, 3 + aw + dw);
      run_vec(rv);
    end

    // Abort: PSEL drops during ADDR; AHB transfer completes, no PREADY
    begin
      int pr_cnt;
      rv = mk(1, 16'h0070, 32'h1122_3344, 4'b1111, 3'b000, 0, 0, 0, 32'h0,
              1, 32'h4000_0070, 3'b010, 4'b0001, 0, 32'h0, 0);
      @(posedge HCLK); #1;
      apb_setup(rv);
      @(posedge HCLK); #1;
      bus.PENABLE = 1'b1;
      ahb_step();
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      pr_cnt = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge HCLK); #1;
        if (bus.PREADY) pr_cnt++;
        ahb_step();
      end
      check("abort_pready_count", pr_cnt, 0);
      check("abort_nonseq_count", nonseq_cnt, 1);
      check("abort_busy", BUSY, 1'b0);
    end

    // Async reset asserted while in DATA with the slave stalling
    rv = mk(0, 16'h0060, 32'h0, 4'b0000, 3'b000, 0, 10, 0, 32'h0,
            1, 32'h4000_0060, 3'b010, 4'b0001, 0, 32'h0, 0);
    @(posedge HCLK); #1;
    apb_setup(rv);
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    ahb_step();
    @(posedge HCLK); #1;
    ahb_step();
    check("pre_reset_state", state_dbg, 2'd2);
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_htrans", bus.HTRANS, 2'b00);
    check("arst_pready", bus.PREADY, 1'b0);
    check("arst_busy", BUSY, 1'b0);
    check("arst_haddr", bus.HADDR, 32'h0);
    check("arst_state", state_dbg, 2'd0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    in_data = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    run_vec(tab[0]);
    run_vec(tab[1]);

    check("ahb_queue_drained", ahb_exp_q.size(), 0);
    check("resp_queue_drained", resp_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
